// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration instead of CPU priority).
package mem_arb_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between CPU and loader, with starvation counter (default) or
// round-robin last-owner register when MEM_ARB_RR_EN is defined.
module mem_arb_grant
  import mem_arb_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arb_en_i,
  input  logic cpu_req_i,
  input  logic ld_req_i,
  output logic gnt_o,
  output logic owner_o
);

  assign gnt_o = arb_en_i & (cpu_req_i | ld_req_i);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  always_comb begin
    if (cpu_req_i && ld_req_i) begin
      owner_o = (last_q == OWN_CPU) ? OWN_LD : OWN_CPU;
    end else begin
      owner_o = ld_req_i ? OWN_LD : OWN_CPU;
    end
  end

  // Resets to loader so the CPU takes the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_LD;
    end else if (gnt_o) begin
      last_q <= owner_o;
    end
  end
`else
  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CntW-1:0] starve_q, starve_d;
  logic            starved;

  assign starved = (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    owner_o  = OWN_CPU;
    starve_d = starve_q;
    if (cpu_req_i && ld_req_i) begin
      if (starved) begin
        owner_o  = OWN_LD;
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end else if (ld_req_i) begin
      owner_o  = OWN_LD;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (gnt_o) begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: rtl/mem_data_arbiter.sv
// Data-memory arbiter between the MEM stage and the loader/debug port.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration, no starvation counter).
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
`ifndef MEM_ARB_RR_EN
  ,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  output logic             o_cpu_stall,
  output logic             o_cpu_valid,
  output logic [WIDTH-1:0] o_cpu_rdata,
  input  logic             i_ld_req,
  input  logic             i_ld_we,
  input  logic [WIDTH-1:0] i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_wdata,
  output logic             o_ld_gnt,
  output logic             o_ld_valid,
  output logic [WIDTH-1:0] o_ld_rdata,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             load;
  logic             owner_q, we_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [WIDTH-1:0] cpu_rdata_q, ld_rdata_q;
  logic             gnt, gnt_owner, sel_ld;
  logic             arb_en, busy, done, capture;

  assign arb_en = (state_q == IDLE);
  assign sel_ld = (gnt_owner == OWN_LD);

`ifdef MEM_ARB_RR_EN
  mem_arb_grant u_grant (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .arb_en_i  (arb_en),
    .cpu_req_i (i_cpu_req),
    .ld_req_i  (i_ld_req),
    .gnt_o     (gnt),
    .owner_o   (gnt_owner)
  );
`else
  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .arb_en_i  (arb_en),
    .cpu_req_i (i_cpu_req),
    .ld_req_i  (i_ld_req),
    .gnt_o     (gnt),
    .owner_o   (gnt_owner)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = BUSY;
          cnt_d   = CntW'(MEM_LAT - 1);
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command latch: memory sees a stable command for the whole access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      owner_q <= gnt_owner;
      we_q    <= sel_ld ? i_ld_we    : i_cpu_we;
      addr_q  <= sel_ld ? i_ld_addr  : i_cpu_addr;
      wdata_q <= sel_ld ? i_ld_wdata : i_cpu_wdata;
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign capture = busy & (cnt_q == '0) & ~we_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else if (capture) begin
      if (owner_q == OWN_LD) begin
        ld_rdata_q <= i_mem_rdata;
      end else begin
        cpu_rdata_q <= i_mem_rdata;
      end
    end
  end

  assign o_mem_read  = busy & ~we_q;
  assign o_mem_write = busy & we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

  assign o_cpu_valid = done & (owner_q == OWN_CPU);
  assign o_ld_valid  = done & (owner_q == OWN_LD);
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_ld_rdata  = ld_rdata_q;

  assign o_cpu_stall = i_cpu_req & ~o_cpu_valid;
  assign o_ld_gnt    = gnt & sel_ld;

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Arbitrates the data memory between two requesters:
  - the pipeline MEM stage (CPU port);
  - a loader/debug port used for program and data preload.
- Issues one access at a time, holds the memory command stable for MEM_LAT cycles, and returns read data with a one-cycle valid pulse.
- Stalls the pipeline while a CPU access is pending.
- Sits between the MEM stage and the data memory instance.

Parameters:
- WIDTH, 32, data/address width (same as datapath).
- MEM_LAT, 2, cycles the data memory needs per access; legal range >= 1.
- STARVE_MAX, 4, consecutive lost arbitrations after which the loader wins.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cpu_req  in  1  MEM stage access request (MemRead | MemWrite).
- i_cpu_we  in  1  1 = write, 0 = read.
- i_cpu_addr  in  WIDTH  CPU address.
- i_cpu_wdata  in  WIDTH  CPU write data.
- o_cpu_stall  out  1  pipeline stall.
- o_cpu_valid  out  1  one-cycle pulse: CPU access completed.
- o_cpu_rdata  out  WIDTH  CPU read data, held until the next CPU completion.
- i_ld_req  in  1  loader request; held until o_ld_valid.
- i_ld_we  in  1  loader write enable.
- i_ld_addr  in  WIDTH  loader address.
- i_ld_wdata  in  WIDTH  loader write data.
- o_ld_gnt  out  1  one-cycle pulse: loader request accepted.
- o_ld_valid  out  1  one-cycle pulse: loader access completed.
- o_ld_rdata  out  WIDTH  loader read data, held until the next loader completion.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_mem_addr  out  WIDTH  memory address.
- o_mem_wdata  out  WIDTH  memory write data.
- i_mem_rdata  in  WIDTH  memory read data; valid in the last BUSY cycle.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, starvation counter 0, latched command cleared.
- FSM states and transitions:
  - IDLE:
    - no request → stay;
    - otherwise grant one requester;
    - latch owner, we, addr, wdata;
    - cnt = MEM_LAT-1;
    - pulse o_ld_gnt if the loader is granted;
    - go BUSY.
  - BUSY:
    - o_mem_read = ~we, o_mem_write = we; addr/wdata from the latch, stable for all MEM_LAT cycles;
    - cnt != 0 → decrement;
    - cnt == 0 → capture i_mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), go DONE.
  - DONE:
    - pulse the owner's valid;
    - memory enables 0;
    - no grant in this cycle, so a CPU request still high while the pipeline advances is not re-served;
    - go IDLE.
- Latency: request in IDLE → valid MEM_LAT+1 cycles later; occupancy is MEM_LAT+2 cycles per access.
- o_cpu_stall = i_cpu_req & ~o_cpu_valid (combinational on the registered valid). Stall is low exactly in the DONE cycle of a CPU access.
- Arbitration when both request in IDLE:
  - CPU wins, starvation counter +1;
  - if the counter == STARVE_MAX, the loader wins instead;
  - the counter clears whenever the loader is granted.
- Single requester: always granted; the counter is unchanged on a lone CPU grant.
- Requests arriving during BUSY/DONE wait; the CPU stays stalled.
- Request inputs are sampled only in IDLE; changes during BUSY are ignored.
- Reset mid-access: memory enables drop immediately (async); the in-flight write is not guaranteed; no valid is produced.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - strict round-robin: on contention the requester not served last wins;
  - STARVE_MAX and the starvation counter are unused and removed;
  - a last-owner flip-flop resets to "loader", so the CPU wins the first contention.
- Undefined: CPU-priority with starvation counter as above.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state typedef (IDLE, BUSY, DONE);
  - owner enum (OWN_CPU, OWN_LD);
  - default WIDTH/MEM_LAT constants.
- One natural sub-module, mem_arb_grant: combinational grant decision plus the starvation counter or last-owner register. The top holds the FSM, latency counter, command latch and rdata registers.

Test Plan:
- MEM_LAT=2; CPU read addr 0x10 while memory returns 0xDEADBEEF:
  - o_mem_read high 2 cycles;
  - o_cpu_valid 3 cycles after request;
  - o_cpu_rdata=0xDEADBEEF;
  - o_cpu_stall high 3 cycles, low in the valid cycle.
- Loader write 0x20←0x12345678:
  - o_ld_gnt pulses in the request cycle;
  - o_mem_write high 2 cycles with stable addr/data;
  - o_ld_valid pulses;
  - o_ld_rdata unchanged.
- CPU and loader both requesting continuously (STARVE_MAX=4):
  - grants go CPU×4, then loader, then CPU×4;
  - no back-to-back grants without an intervening DONE cycle.
- CPU request held high through the DONE cycle then dropped: exactly one memory access, not two.
- Async reset asserted mid-BUSY of a write: o_mem_write falls without a clock edge; no valid pulse; after release, a new CPU read completes normally.
- With MEM_ARB_RR_EN and both requesting: grants alternate CPU, loader, CPU, loader…; the first contention goes to the CPU.
